seg_capture_decoder: RTL and testbench
======================================

Name: seg_capture_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder. Observes a multiplexed, active-low seven-segment bus (segments + digit anodes).
- Qualifies each digit's pattern for stability, decodes it back to a 4-bit hex nibble plus decimal point, and assembles whole display frames.
- Used as a display self-check monitor and as a loopback source for the LED output path.

Parameters:
- DIGITS, 4, number of multiplexed digits (anode width); range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; range 2..255.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Seg  input  8  segment bus, active-low (0 = lit). Bit 7 = a, bits 6..1 = b..g, bit 0 = dp.
- Anode  input  DIGITS  digit enables, active-low, one-hot when valid.
- Digit  output  4*DIGITS  per-digit decoded nibble; digit i at [4i+3:4i].
- Dp  output  DIGITS  per-digit decimal point, 1 = lit.
- Blank  output  DIGITS  per-digit blank flag (all of a..g dark).
- Err  output  DIGITS  sticky flag: digit i received an undecodable pattern.
- FrameValue  output  4*DIGITS  snapshot of Digit taken when a frame completes.
- FrameDone  output  1  one-cycle pulse when every digit has been captured since the last frame.

Behaviour:
- Reset (Reset = 0, asynchronous): all outputs 0; stability counter 0; seen mask 0; captured flag 0; sample registers = 8'hFF / all-ones.
- Input sampling: Seg and Anode are registered once on each CLK edge. All comparisons use the registered copy and the previous registered copy.
- Decode, bits 7..1 → nibble:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6
  - 0001111→7, 0000000→8, 0000100→9, 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F
  - 1111111 → blank.
  - Any other pattern → invalid.
  - Dp = ~Seg[0].
- Stability counter:
  - Anode valid means exactly one bit is low.
  - The counter increments when the registered {Seg, Anode} equals the previous sample and Anode is valid. It saturates at STABLE_CYCLES.
  - On any change, or on invalid Anode: counter returns to 1 if Anode is valid, else 0, and the captured flag clears.
- Capture:
  - Fires on the cycle the counter reaches STABLE_CYCLES with the captured flag clear. The captured flag then sets, giving exactly one capture per dwell.
  - Valid pattern: Digit[i] takes the decoded nibble, Blank[i] = 0, Dp[i] is updated, seen[i] is set.
  - Blank pattern: Blank[i] = 1, Dp[i] is updated, Digit[i] holds, seen[i] is set.
  - Invalid pattern: Err[i] = 1 (sticky until reset), Digit/Blank/Dp hold, seen[i] is NOT set.
- Latency: Digit is updated STABLE_CYCLES+1 cycles after the first stable Seg/Anode value appears at the inputs.
- Frame completion:
  - When seen would become all-ones, counting the current capture, FrameDone pulses high for one cycle.
  - On that same cycle: FrameValue takes Digit including the current capture, and seen clears to 0.
- Recapturing an already-seen digit before the frame completes overwrites Digit[i]; seen is unchanged.
- A digit change between Anode scans restarts qualification. Glitches shorter than STABLE_CYCLES never capture.
- Reset mid-frame discards partial frame state and Err.

Decomposition:
- Shared package seg_pkg:
  - segment bit-index constants (SEG_A..SEG_G, SEG_DP);
  - the 16 active-low glyph constants (shared with the encoder);
  - SEG_BLANK = 7'b1111111.
- Sub-module seg_to_hex: combinational 7-bit pattern → {valid, blank, nibble[3:0]}.
- The top level holds the sampler, stability counter, capture logic and frame assembler.

Test Plan:
- Reset asserted mid-dwell (Anode = 4'b1110, Seg = 8'h03 held 2 cycles) -> all outputs 0 immediately; no capture after release until 4 fresh stable cycles.
- Anode = 4'b1110, Seg = 8'h9F held 10 cycles -> Digit[3:0] = 1 exactly 5 cycles after the stimulus appears; only one capture occurs; Dp[0] = 0.
- Scan digits 0..3 with 0x25, 0x0D, 0x99, 0x49 (dp lit on digit 2, Seg = 8'h98), 6 cycles each -> FrameDone single pulse on the digit 3 capture; FrameValue = 16'h5432; Dp = 4'b0100.
- Digit 1 shows Seg = 8'hFE (bits 7..1 all dark, dp lit) -> Blank[1] = 1, Dp[1] = 1, Digit[7:4] unchanged; the frame still completes.
- Digit 2 shows 8'hAA (invalid) -> Err[2] = 1 and sticky; no FrameDone until a valid or blank digit 2 is captured.
- Seg toggles each cycle between 8'h03 and 8'h9F, then Anode = 4'b1100 (two low bits) held 8 cycles -> no capture, Digit unchanged, counter stays below threshold.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions.
// Segment bus is active-low (0 = lit). Bit 7 = a, bits 6..1 = b..g, bit 0 = dp.
// The glyph table is the same one the encoder drives, so both ends agree on
// the digit shapes.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low a..g patterns, entry i is hex glyph i.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef struct packed {
    logic       valid;   // pattern is one of the 16 glyphs
    logic       blank;   // all of a..g dark
    logic [3:0] nibble;  // decoded value, 0 unless valid
  } hex_dec_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational glyph decoder.
// Ports: pat - active-low a..g pattern (a in bit 6)
//        dec - {valid, blank, nibble}; neither flag set means undecodable.
module seg_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pat,
  output hex_dec_t   dec
);

  always_comb begin
    dec = '0;
    if (pat == SEG_BLANK) begin
      dec.blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pat == SEG_GLYPHS[i]) begin
          dec.valid  = 1'b1;
          dec.nibble = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seg_capture_decoder.sv
// Seven-segment bus capture monitor.
// Samples a multiplexed active-low segment/anode bus, waits for each digit's
// pattern to hold for STABLE_CYCLES samples, decodes it and assembles frames.
// Ports: CLK, Reset (async, active-low)
//        Seg[7:0]          segment bus, active-low, a in bit 7, dp in bit 0
//        Anode[DIGITS-1:0] digit enables, active-low one-hot
//        Digit             per-digit nibble, digit i at [4i+3:4i]
//        Dp / Blank / Err  per-digit dp lit, all-dark, sticky undecodable
//        FrameValue        Digit snapshot at frame completion
//        FrameDone         one-cycle pulse when all digits captured
module seg_capture_decoder
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [7:0]            Seg,
  input  logic [DIGITS-1:0]     Anode,
  output logic [4*DIGITS-1:0]   Digit,
  output logic [DIGITS-1:0]     Dp,
  output logic [DIGITS-1:0]     Blank,
  output logic [DIGITS-1:0]     Err,
  output logic [4*DIGITS-1:0]   FrameValue,
  output logic                  FrameDone
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [7:0]          seg_q, seg_p;
  logic [DIGITS-1:0]   an_q, an_p;
  logic [7:0]          cnt, cnt_nxt;
  logic                captured;
  logic [DIGITS-1:0]   seen, seen_nxt;
  logic                an_ok, same, fire, frame;
  logic [DIGITS-1:0]   sel;
  hex_dec_t            dec;
  logic [4*DIGITS-1:0] digit_nxt;
  logic [DIGITS-1:0]   dp_nxt, blank_nxt, err_nxt;

  seg_to_hex u_dec (
    .pat (seg_q[SEG_A:SEG_G]),
    .dec (dec)
  );

  assign sel   = ~an_q;
  assign an_ok = $onehot(sel);
  assign same  = (seg_q == seg_p) && (an_q == an_p);

  always_comb begin
    if (same && an_ok) cnt_nxt = (cnt >= STABLE) ? STABLE : cnt + 8'd1;
    else               cnt_nxt = an_ok ? 8'd1 : 8'd0;
  end

  // Single capture per dwell: only the cycle the count first hits threshold.
  assign fire = same && an_ok && (cnt_nxt == STABLE) && !captured;

  always_comb begin
    digit_nxt = Digit;
    dp_nxt    = Dp;
    blank_nxt = Blank;
    err_nxt   = Err;
    seen_nxt  = seen;
    if (fire) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel[i]) begin
          if (dec.valid) begin
            digit_nxt[4*i +: 4] = dec.nibble;
            blank_nxt[i]        = 1'b0;
            dp_nxt[i]           = ~seg_q[SEG_DP];
            seen_nxt[i]         = 1'b1;
          end else if (dec.blank) begin
            blank_nxt[i] = 1'b1;
            dp_nxt[i]    = ~seg_q[SEG_DP];
            seen_nxt[i]  = 1'b1;
          end else begin
            err_nxt[i] = 1'b1;
          end
        end
      end
    end
  end

  // Frame closes on the capture that fills the seen mask.
  assign frame = fire && (&seen_nxt);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      seg_q      <= 8'hFF;
      seg_p      <= 8'hFF;
      an_q       <= '1;
      an_p       <= '1;
      cnt        <= '0;
      captured   <= 1'b0;
      seen       <= '0;
      Digit      <= '0;
      Dp         <= '0;
      Blank      <= '0;
      Err        <= '0;
      FrameValue <= '0;
      FrameDone  <= 1'b0;
    end else begin
      seg_q     <= Seg;
      an_q      <= Anode;
      seg_p     <= seg_q;
      an_p      <= an_q;
      cnt       <= cnt_nxt;
      if (!(same && an_ok)) captured <= 1'b0;
      else if (fire)        captured <= 1'b1;
      Digit     <= digit_nxt;
      Dp        <= dp_nxt;
      Blank     <= blank_nxt;
      Err       <= err_nxt;
      FrameDone <= frame;
      if (frame) begin
        FrameValue <= digit_nxt;
        seen       <= '0;
      end else begin
        seen       <= seen_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_capture_decoder.sv
module tb_seg_capture_decoder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [7:0]  Seg;
  logic [3:0]  Anode;
  logic [15:0] Digit;
  logic [3:0]  Dp, Blank, Err;
  logic [15:0] FrameValue;
  logic        FrameDone;

  int errors = 0;
  int checks = 0;
  int frames = 0;

  // Expected frames: {FrameValue[15:0], Dp[3:0]}
  logic [19:0] exp_q[$];

  seg_capture_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Seg        (Seg),
    .Anode      (Anode),
    .Digit      (Digit),
    .Dp         (Dp),
    .Blank      (Blank),
    .Err        (Err),
    .FrameValue (FrameValue),
    .FrameDone  (FrameDone)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply a bus value just after an edge and hold it for n rising edges.
  task automatic drive(input logic [7:0] s, input logic [3:0] a, input int n);
    Seg   = s;
    Anode = a;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (Reset === 1'b1 && FrameDone === 1'b1) begin
      logic [19:0] e;
      frames++;
      if (exp_q.size() == 0) begin
        chk("frame_unexpected", 32'(FrameDone), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("frame_value", 32'(FrameValue), 32'(e[19:4]));
        chk("frame_dp", 32'(Dp), 32'(e[3:0]));
      end
    end
  end

  initial begin
    Reset = 1'b0;
    Seg   = 8'hFF;
    Anode = 4'hF;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_digit", 32'(Digit), 32'h0);
    chk("rst_flags", 32'({Dp, Blank, Err}), 32'h0);
    chk("rst_frame", 32'({FrameValue, FrameDone}), 32'h0);
    Reset = 1'b1;

    // Single digit: latency is STABLE_CYCLES+1 edges, one capture per dwell
    drive(8'h9F, 4'hE, 4);
    chk("lat_early", 32'(Digit), 32'h0);
    drive(8'h9F, 4'hE, 1);
    chk("lat_hit", 32'(Digit[3:0]), 32'h1);
    drive(8'h9F, 4'hE, 5);
    chk("hold_digit", 32'(Digit), 32'h0001);
    chk("hold_dp", 32'(Dp[0]), 32'h0);

    // Reset mid-dwell clears immediately; re-qualification starts fresh
    drive(8'h03, 4'hE, 2);
    Reset = 1'b0;
    #1;
    chk("mid_rst_digit", 32'(Digit), 32'h0);
    chk("mid_rst_flags", 32'({Dp, Blank, Err, FrameDone}), 32'h0);
    Seg = 8'h9F;
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    drive(8'h9F, 4'hE, 4);
    chk("rst_nocap", 32'(Digit), 32'h0);
    drive(8'h9F, 4'hE, 1);
    chk("rst_recap", 32'(Digit[3:0]), 32'h1);

    // Full frame scan, dp lit on digit 2
    exp_q.push_back({16'h5432, 4'b0100});
    drive(8'h25, 4'hE, 6);
    drive(8'h0D, 4'hD, 6);
    drive(8'h98, 4'hB, 6);
    chk("pre_frame_cnt", 32'(frames), 32'd0);
    drive(8'h49, 4'h7, 6);
    chk("frame1_cnt", 32'(frames), 32'd1);
    chk("frame1_digit", 32'(Digit), 32'h5432);
    chk("frame1_blank", 32'(Blank), 32'h0);

    // Blank digit 1 with dp lit still completes a frame
    exp_q.push_back({16'h5432, 4'b0010});
    drive(8'h25, 4'hE, 6);
    drive(8'hFE, 4'hD, 6);
    chk("blank_flag", 32'(Blank), 32'b0010);
    chk("blank_hold", 32'(Digit[7:4]), 32'h3);
    chk("blank_dp", 32'(Dp[1]), 32'h1);
    drive(8'h99, 4'hB, 6);
    drive(8'h49, 4'h7, 6);
    chk("frame2_cnt", 32'(frames), 32'd2);

    // Invalid digit 2 is sticky and blocks the frame until a good capture
    drive(8'h25, 4'hE, 6);
    drive(8'h0D, 4'hD, 6);
    drive(8'hAA, 4'hB, 6);
    chk("err_set", 32'(Err), 32'b0100);
    chk("err_digit_hold", 32'(Digit[11:8]), 32'h4);
    drive(8'h49, 4'h7, 6);
    chk("err_noframe", 32'(frames), 32'd2);
    exp_q.push_back({16'h5432, 4'b0100});
    drive(8'h98, 4'hB, 6);
    chk("frame3_cnt", 32'(frames), 32'd3);
    chk("err_sticky", 32'(Err), 32'b0100);

    // Toggling segments and a two-hot anode never capture
    for (int i = 0; i < 10; i++) drive((i % 2) ? 8'h9F : 8'h03, 4'hE, 1);
    chk("toggle_digit", 32'(Digit), 32'h5432);
    drive(8'h03, 4'hC, 8);
    chk("twohot_digit", 32'(Digit), 32'h5432);
    chk("twohot_flags", 32'({Dp, Blank, Err}), 32'h404);
    chk("final_frames", 32'(frames), 32'd3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
